const_level_checker: RTL and testbench
======================================

# const_level_checker

Sequential monitor that watches a line or bus that is meant to sit at a fixed level, such as the output of a constant-driver gate, and flags any cycle where it deviates. It is the receiving end of the constant-source cells in the gate library. It arms on an enable, ignores a programmable settle window, then compares every cycle against the expected value. It keeps a sticky error, a saturating violation count, the cycle index of the first violation, and an accumulated per-bit mismatch mask. It sits beside gate-level blocks in simulation and self-check harnesses.

## Interface
- WIDTH, 1: width of the monitored bus.
- EXPECTED, {WIDTH{1'b0}}: required level of every bit.
- SETTLE, 2: cycles ignored after arming; 0 means checking starts on the first armed cycle.
- CNT_W, 8: width of the violation counter.
- CYC_W, 16: width of the checked-cycle counter and of first_cycle.

Ports:
- clk  in  1  the single clock; everything updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  arm/hold the checker; 0 returns to IDLE.
- clr  in  1  clears result registers without disarming.
- a  in  WIDTH  monitored signal.
- ok  out  1  1 while checking with no violation recorded.
- err  out  1  sticky: at least one violation since the last rst/clr.
- viol_count  out  CNT_W  number of violating cycles, saturating at all-ones.
- first_cycle  out  CYC_W  checked-cycle index of the first violation (0 = first checked cycle).
- mismatch  out  WIDTH  OR-accumulation of (a ^ EXPECTED) over violating cycles.

## Operation
- States: IDLE, SETTLE, CHECK, FAULT.
- IDLE:
  - en=1 with SETTLE>0 goes to SETTLE and loads the settle counter with SETTLE-1.
  - en=1 with SETTLE=0 goes to CHECK.
- SETTLE:
  - a is ignored.
  - The counter decrements each cycle; at 0 the block goes to CHECK.
- CHECK:
  - Each cycle, a is compared with EXPECTED.
  - On any differing bit the block goes to FAULT, sets err, increments viol_count, ORs the mismatching bits into mismatch, and captures the current checked-cycle index into first_cycle.
- FAULT:
  - Checking continues.
  - Each further violating cycle increments viol_count and ORs into mismatch.
  - first_cycle is not rewritten.
- Checked-cycle counter:
  - Zeroed on each entry into SETTLE or CHECK from IDLE.
  - Increments once per cycle spent in CHECK or FAULT.
  - Saturates at all-ones.
- viol_count saturates at all-ones; err stays 1 once set.
- en=0 in any state returns to IDLE on the next edge. err, viol_count, first_cycle and mismatch are retained. Re-arming does not clear them.
- Re-arming after a prior fault enters SETTLE/CHECK, then FAULT on the next violation; first_cycle still holds the original capture.
- clr=1:
  - Zeroes err, viol_count, first_cycle and mismatch.
  - FAULT returns to CHECK; the state is otherwise unchanged.
  - The sample of a on that cycle is discarded: clr has priority over a simultaneous violation.
- ok = 1 exactly in CHECK state; 0 in IDLE, SETTLE and FAULT.

## Timing
- Reset values: state IDLE, ok=0, err=0, viol_count=0, first_cycle=0, mismatch=0, all internal counters 0.
- rst has priority over en and clr.
- rst mid-check aborts to IDLE and clears all results on that edge.
- a is sampled at the rising edge. Outputs reflect that sample after the same edge, so a violation on cycle n is visible on outputs in cycle n+1.
- Arming latency: with en raised before edge 0, the first checked sample is at edge SETTLE+1. With SETTLE=0 it is at edge 1.
- en drop: the block is in IDLE after the next edge, and a on that edge is not checked.
- No combinational path from a, en or clr to any output; all outputs are registered.

## Test plan
- Reset, then en=1, a=0, default parameters, held 20 cycles -> ok=1 from edge 3 onward; err=0; viol_count=0; mismatch=0.
- Armed with SETTLE=2: a=1 during the two settle cycles, then a=0 -> no error. A single a=1 pulse on checked cycle 5 -> next cycle err=1, ok=0, viol_count=1, first_cycle=5, mismatch=1.
- Further pulses, CNT_W=2 -> viol_count climbs to 3 and holds at 3; first_cycle stays 5.
- In FAULT, assert clr together with a=1 -> err=0, viol_count=0, mismatch=0, state CHECK, ok=1. The next a=1 gives first_cycle equal to the new index.
- WIDTH=4, EXPECTED=4'b0000: a=4'b0010, later a=4'b1000 -> mismatch=4'b1010, viol_count=2.
- Drop en in FAULT, then reset mid-check: results held through IDLE. rst during CHECK -> all outputs 0 on the following cycle; re-arm resumes from cycle index 0.

Source files
------------

// File: rtl/const_level_checker.sv
// rtl/const_level_checker.sv - monitors a bus meant to hold a fixed level and records deviations
module const_level_checker #(
    parameter int                 WIDTH    = 1,
    parameter logic [WIDTH-1:0]   EXPECTED = {WIDTH{1'b0}},
    parameter int                 SETTLE   = 2,
    parameter int                 CNT_W    = 8,
    parameter int                 CYC_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [WIDTH-1:0]   a,
    output logic               ok,
    output logic               err,
    output logic [CNT_W-1:0]   viol_count,
    output logic [CYC_W-1:0]   first_cycle,
    output logic [WIDTH-1:0]   mismatch
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_FAULT} state_t;

    localparam int              SET_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = (SETTLE > 0) ? SET_W'(SETTLE - 1) : '0;

    state_t             r_state;
    state_t             w_next;
    logic [SET_W-1:0]   r_set;
    logic [CYC_W-1:0]   r_cyc;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [CYC_W-1:0]   r_first;
    logic [WIDTH-1:0]   r_mis;

    logic [WIDTH-1:0]   w_diff;
    logic               w_checking;
    logic               w_arm;
    logic               w_viol;

    assign w_diff     = a ^ EXPECTED;
    assign w_checking = (r_state == S_CHECK) || (r_state == S_FAULT);
    assign w_arm      = (r_state == S_IDLE) && en;
    // clr discards the sample taken on the same edge
    assign w_viol     = en && w_checking && !clr && (w_diff != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!en) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_next = (SETTLE > 0) ? S_SETTLE : S_CHECK;
                S_SETTLE: w_next = (r_set == '0) ? S_CHECK : S_SETTLE;
                S_CHECK:  w_next = w_viol ? S_FAULT : S_CHECK;
                S_FAULT:  w_next = clr ? S_CHECK : S_FAULT;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ok = 1'b0;
        if (r_state == S_CHECK) begin
            ok = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_set   <= '0;
            r_cyc   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_first <= '0;
            r_mis   <= '0;
        end else begin
            if (w_arm) begin
                r_set <= SET_LOAD;
            end else if (r_state == S_SETTLE && r_set != '0) begin
                r_set <= r_set - SET_W'(1);
            end

            if (w_arm) begin
                r_cyc <= '0;
            end else if (w_checking && r_cyc != '1) begin
                r_cyc <= r_cyc + CYC_W'(1);
            end

            if (clr) begin
                r_err   <= 1'b0;
                r_cnt   <= '0;
                r_first <= '0;
                r_mis   <= '0;
            end else if (w_viol) begin
                r_err <= 1'b1;
                r_mis <= r_mis | w_diff;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                // only the first violation since rst/clr records its index
                if (!r_err) begin
                    r_first <= r_cyc;
                end
            end
        end
    end

    assign err         = r_err;
    assign viol_count  = r_cnt;
    assign first_cycle = r_first;
    assign mismatch    = r_mis;

endmodule

// File: tb/tb_const_level_checker.sv
// tb/tb_const_level_checker.sv - table-driven scoreboard bench for const_level_checker
module tb_const_level_checker;

    localparam logic [3:0] E = 4'b0110;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [3:0]  a;
    logic        ok, err;
    logic [1:0]  viol_count;
    logic [15:0] first_cycle;
    logic [3:0]  mismatch;

    const_level_checker #(
        .WIDTH(4), .EXPECTED(E), .SETTLE(2), .CNT_W(2), .CYC_W(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a),
        .ok(ok), .err(err), .viol_count(viol_count),
        .first_cycle(first_cycle), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, clr;
        logic [3:0]  amask;
        logic        ok, err;
        logic [1:0]  cnt;
        logic [15:0] first;
        logic [3:0]  mis;
    } vec_t;

    typedef struct {
        int          id;
        logic        ok, err;
        logic [1:0]  cnt;
        logic [15:0] first;
        logic [3:0]  mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic e, input logic c, input logic [3:0] m,
                       input logic o, input logic er, input logic [1:0] cn,
                       input logic [15:0] f, input logic [3:0] mi);
        vec_t v;
        v.rst = r; v.en = e; v.clr = c; v.amask = m;
        v.ok = o; v.err = er; v.cnt = cn; v.first = f; v.mis = mi;
        vecs.push_back(v);
    endtask

    task automatic apply(input int id, input vec_t v);
        exp_t x;
        exp_t got;
        @(negedge clk);
        rst = v.rst; en = v.en; clr = v.clr; a = E ^ v.amask;
        x.id = id; x.ok = v.ok; x.err = v.err; x.cnt = v.cnt; x.first = v.first; x.mis = v.mis;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_cmp++;
        if ({ok, err, viol_count, first_cycle, mismatch} !==
            {got.ok, got.err, got.cnt, got.first, got.mis}) begin
            n_bad++;
            $display("FAIL step%0d: got ok=%b err=%b cnt=%0d first=%0d mis=%b, want ok=%b err=%b cnt=%0d first=%0d mis=%b",
                     got.id, ok, err, viol_count, first_cycle, mismatch,
                     got.ok, got.err, got.cnt, got.first, got.mis);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; a = E;
        //   rst en clr amask    ok err cnt first mis
        add(1, 0, 0, 4'b0000,  0, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b1111,  0, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b1111,  0, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b1111,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0001,  0, 1, 1,  5, 4'b0001);
        add(0, 1, 0, 4'b0000,  0, 1, 1,  5, 4'b0001);
        add(0, 1, 0, 4'b1000,  0, 1, 2,  5, 4'b1001);
        add(0, 1, 0, 4'b0001,  0, 1, 3,  5, 4'b1001);
        add(0, 1, 0, 4'b0010,  0, 1, 3,  5, 4'b1011);
        add(0, 1, 1, 4'b0100,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0010,  0, 1, 1, 12, 4'b0010);
        add(0, 1, 0, 4'b1000,  0, 1, 2, 12, 4'b1010);
        add(0, 0, 0, 4'b0001,  0, 1, 2, 12, 4'b1010);
        add(0, 0, 0, 4'b0001,  0, 1, 2, 12, 4'b1010);
        add(0, 1, 0, 4'b0000,  0, 1, 2, 12, 4'b1010);
        add(0, 1, 0, 4'b0000,  0, 1, 2, 12, 4'b1010);
        add(0, 1, 0, 4'b0100,  1, 1, 2, 12, 4'b1010);
        add(0, 1, 0, 4'b0000,  1, 1, 2, 12, 4'b1010);
        add(0, 1, 0, 4'b0001,  0, 1, 3, 12, 4'b1011);
        add(0, 1, 1, 4'b0000,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  1, 0, 0,  0, 4'b0000);
        add(1, 1, 0, 4'b1111,  0, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  0, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  0, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0000,  1, 0, 0,  0, 4'b0000);
        add(0, 1, 0, 4'b0100,  0, 1, 1,  1, 4'b0100);
        add(0, 0, 1, 4'b0000,  0, 0, 0,  0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // long clean run after arming: ok rises after the settle window and stays up
        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v.rst = 0; v.en = 1; v.clr = 0; v.amask = 4'b0000;
            v.ok = (i >= 2); v.err = 0; v.cnt = 0; v.first = 0; v.mis = 0;
            apply(100 + i, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
